// File: rtl/decompressor_stream_parser.sv
// LZRW1 stream front end: splits control-byte groups into literal/copy items
// and presents them one at a time to decompressor_top, paced by its busy flag.
module decompressor_stream_parser #(
  parameter int unsigned GROUP_SIZE  = 8,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             in_byte,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [15:0]            data_out,
  output logic                   control_word_out,
  output logic                   data_out_valid,
  input  logic                   decompressor_busy,
  output logic                   done,
  output logic                   protocol_error,
  output logic [COUNT_WIDTH-1:0] item_count
);

  typedef enum logic [1:0] {
    S_CTRL,
    S_ITEM1,
    S_ITEM2,
    S_PRESENT
  } state_t;

  state_t                 state_q;
  logic [7:0]             ctrl_q;
  logic [2:0]             idx_q;
  logic [7:0]             hi_q;
  logic                   last_pending_q;
  logic [15:0]            data_q;
  logic                   cw_q;
  logic                   valid_q;
  logic                   done_q;
  logic                   perr_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic take;
  logic accept;
  logic is_copy;

  assign in_ready = !reset && (state_q != S_PRESENT);
  assign take     = in_valid && in_ready;
  assign accept   = valid_q && !decompressor_busy;
  // Item 0 uses the MSB of the control byte.
  assign is_copy  = ctrl_q[3'd7 - idx_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_CTRL;
      ctrl_q         <= '0;
      idx_q          <= '0;
      hi_q           <= '0;
      last_pending_q <= 1'b0;
      data_q         <= '0;
      cw_q           <= 1'b0;
      valid_q        <= 1'b0;
      done_q         <= 1'b0;
      perr_q         <= 1'b0;
      count_q        <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_CTRL: begin
          if (take) begin
            ctrl_q <= in_byte;
            idx_q  <= '0;
            if (in_last) done_q  <= 1'b1;
            else         state_q <= S_ITEM1;
          end
        end
        S_ITEM1: begin
          if (take) begin
            if (is_copy) begin
              // High byte is kept aside so a truncated copy never disturbs data_out.
              hi_q <= in_byte;
              if (in_last) begin
                perr_q  <= 1'b1;
                state_q <= S_CTRL;
              end else begin
                state_q <= S_ITEM2;
              end
            end else begin
              data_q         <= {8'h00, in_byte};
              cw_q           <= 1'b0;
              last_pending_q <= in_last;
              valid_q        <= 1'b1;
              state_q        <= S_PRESENT;
            end
          end
        end
        S_ITEM2: begin
          if (take) begin
            data_q         <= {hi_q, in_byte};
            cw_q           <= 1'b1;
            last_pending_q <= in_last;
            valid_q        <= 1'b1;
            state_q        <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (accept) begin
            valid_q <= 1'b0;
            count_q <= count_q + COUNT_WIDTH'(1);
            if (last_pending_q) begin
              done_q  <= 1'b1;
              state_q <= S_CTRL;
            end else if (idx_q == 3'(GROUP_SIZE - 1)) begin
              state_q <= S_CTRL;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= S_ITEM1;
            end
          end
        end
        default: state_q <= S_CTRL;
      endcase
    end
  end

  assign data_out         = data_q;
  assign control_word_out = cw_q;
  assign data_out_valid   = valid_q;
  assign done             = done_q;
  assign protocol_error   = perr_q;
  assign item_count       = count_q;

endmodule

// File: tb/tb_decompressor_stream_parser.sv
// Scoreboard bench for decompressor_stream_parser: expected items are queued as
// their final byte is driven and checked when the parser hands them downstream.
module tb_decompressor_stream_parser;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] data_out;
  logic        control_word_out;
  logic        data_out_valid;
  logic        decompressor_busy;
  logic        done;
  logic        protocol_error;
  logic [15:0] item_count;

  decompressor_stream_parser #(.GROUP_SIZE(8), .COUNT_WIDTH(16)) dut (
    .clock             (clock),
    .reset             (reset),
    .in_byte           (in_byte),
    .in_valid          (in_valid),
    .in_last           (in_last),
    .in_ready          (in_ready),
    .data_out          (data_out),
    .control_word_out  (control_word_out),
    .data_out_valid    (data_out_valid),
    .decompressor_busy (decompressor_busy),
    .done              (done),
    .protocol_error    (protocol_error),
    .item_count        (item_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] d;
    logic        cw;
    logic        last;
  } item_t;

  item_t       sb[$];
  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  int unsigned done_seen  = 0;
  int unsigned exp_count  = 0;
  int unsigned gap_max    = 0;
  logic        chk_done   = 1'b0;
  logic        done_exp   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: an accept happens at the next rising edge when valid && !busy here.
  initial begin
    item_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk_done = 1'b0;
      end else begin
        if (done) done_seen++;
        if (chk_done) begin
          check("done_after_accept", 32'(done), 32'(done_exp));
          chk_done = 1'b0;
        end
        if (data_out_valid && !decompressor_busy) begin
          if (sb.size() == 0) begin
            check("spurious_item", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            check("data_out", 32'(data_out), 32'(e.d));
            check("control_word_out", 32'(control_word_out), 32'(e.cw));
            done_exp = e.last;
            chk_done = 1'b1;
          end
        end
      end
    end
  end

  // Entered and left at posedge+1; byte is taken on the edge after in_ready is seen.
  task automatic send(input logic [7:0] b, input logic last);
    int unsigned g;
    bit ok;
    g = (gap_max == 0) ? 0 : $urandom_range(gap_max, 0);
    repeat (g) begin
      @(posedge clock);
      #1;
    end
    in_byte  = b;
    in_last  = last;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("in_ready_timeout", 32'(ok), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_byte  = 8'hxx;
  endtask

  task automatic lit(input logic [7:0] b, input logic last);
    item_t e;
    e.d = {8'h00, b}; e.cw = 1'b0; e.last = last;
    sb.push_back(e);
    exp_count++;
    send(b, last);
  endtask

  task automatic cpy(input logic [7:0] h, input logic [7:0] l, input logic last);
    item_t e;
    send(h, 1'b0);
    e.d = {h, l}; e.cw = 1'b1; e.last = last;
    sb.push_back(e);
    exp_count++;
    send(l, last);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) check("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic all_literals();
    int unsigned d0;
    d0 = done_seen;
    send(8'h00, 1'b0);
    for (int i = 0; i < 8; i++) lit(8'h41 + 8'(i), (i == 7));
    drain();
    check("lit_done_count", 32'(done_seen - d0), 32'd1);
    check("lit_item_count", 32'(item_count), 32'(exp_count));
  endtask

  initial begin
    int unsigned d0;
    reset = 1'b1; in_byte = '0; in_valid = 1'b0; in_last = 1'b0; decompressor_busy = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(data_out_valid), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_count", 32'(item_count), 32'd0);
    check("rst_perr", 32'(protocol_error), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;

    // All literals.
    all_literals();

    // Copy then literal.
    d0 = done_seen;
    send(8'h80, 1'b0);
    cpy(8'h12, 8'h34, 1'b0);
    lit(8'h78, 1'b1);
    drain();
    check("cl_done_count", 32'(done_seen - d0), 32'd1);
    check("cl_item_count", 32'(item_count), 32'(exp_count));

    // Backpressure on the first item, then finish the group normally.
    d0 = done_seen;
    send(8'h00, 1'b0);
    decompressor_busy = 1'b1;
    lit(8'h41, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("busy_data_stable", 32'(data_out), 32'h0041);
      check("busy_valid", 32'(data_out_valid), 32'd1);
      check("busy_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clock); #1;
    decompressor_busy = 1'b0;
    for (int i = 1; i < 8; i++) lit(8'h41 + 8'(i), (i == 7));
    drain();
    check("bp_done_count", 32'(done_seen - d0), 32'd1);
    check("bp_item_count", 32'(item_count), 32'(exp_count));

    // Same literal stream with random input gaps.
    gap_max = 3;
    all_literals();
    gap_max = 0;

    // Group wrap: 8th item is a copy, then a second control byte.
    d0 = done_seen;
    send(8'h01, 1'b0);
    for (int i = 0; i < 7; i++) lit(8'h30 + 8'(i), 1'b0);
    cpy(8'hAB, 8'hCD, 1'b0);
    send(8'h00, 1'b0);
    lit(8'h5A, 1'b1);
    drain();
    check("wrap_done_count", 32'(done_seen - d0), 32'd1);
    check("wrap_item_count", 32'(item_count), 32'(exp_count));

    // Truncated copy: error, no done, then the next byte is a control byte.
    d0 = done_seen;
    send(8'h40, 1'b0);
    lit(8'h61, 1'b0);
    send(8'h05, 1'b1);
    drain();
    check("perr_set", 32'(protocol_error), 32'd1);
    check("perr_no_done", 32'(done_seen - d0), 32'd0);
    check("perr_item_count", 32'(item_count), 32'(exp_count));
    check("perr_back_to_ctrl", 32'(in_ready), 32'd1);
    d0 = done_seen;
    send(8'h00, 1'b0);
    lit(8'h42, 1'b1);
    drain();
    check("perr_sticky", 32'(protocol_error), 32'd1);
    check("perr_recover_done", 32'(done_seen - d0), 32'd1);

    // Reset while waiting for the second byte of a copy.
    send(8'h80, 1'b0);
    send(8'h12, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(data_out_valid), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'd0);
    check("mid_rst_cw", 32'(control_word_out), 32'd0);
    check("mid_rst_perr", 32'(protocol_error), 32'd0);
    check("mid_rst_count", 32'(item_count), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    exp_count = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    d0 = done_seen;
    send(8'h00, 1'b0);
    lit(8'h41, 1'b1);
    drain();
    check("after_rst_done_count", 32'(done_seen - d0), 32'd1);
    check("after_rst_item_count", 32'(item_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
